exmem_pipe_stage: RTL and testbench
===================================

// Module: exmem_pipe_stage
// PURPOSE
//  Parametrised EX/MEM pipeline stage register, next generation of the fixed 73-bit latch.
//  - Adds valid/ready handshake, downstream stall (backpressure) and flush/bubble insertion.
//  - Optional 2-entry skid buffer gives a fully registered in_ready.
//  - Adds a saturating stall counter for performance monitoring.
//  - Sits between the EX stage (ALU, forwarding) and the MEM stage (data memory, load/store).
// PARAMETERS
//  WB_W     2   width of write-back control field
//  M_W      2   width of memory control field
//  DATA_W   32  width of ALU result and store data
//  REGD_W   5   width of destination register index
//  SKID_EN  1   1: 2-entry skid buffer, registered in_ready; 0: single entry, combinational in_ready
//  CNT_W    16  width of saturating stall counter
// PORTS
//  clk            in   1       rising-edge clock, single clock domain
//  reset_in       in   1       synchronous, active-high reset
//  flush_in       in   1       kill all held entries (branch/exception redirect)
//  in_valid       in   1       EX stage presents a valid bundle
//  in_ready       out  1       stage accepts bundle this cycle
//  WB_in          in   WB_W    write-back control
//  M_in           in   M_W     memory control
//  ALUData_in     in   DATA_W  ALU result / address
//  WriteData_in   in   DATA_W  store data
//  Regd_in        in   REGD_W  destination register
//  out_valid      out  1       MEM stage sees a valid bundle
//  out_ready      in   1       MEM stage consumes bundle this cycle
//  WB_out, M_out, ALUData_out, WriteData_out, Regd_out  out  as inputs  registered bundle
//  stall_cnt      out  CNT_W   cycles with out_valid=1 and out_ready=0, saturates at all-ones
// BEHAVIOUR
//  - Reset (reset_in=1 at posedge): all entries empty, all payload regs 0, out_valid=0,
//    stall_cnt=0. in_ready=1 from the first cycle after reset when SKID_EN=1.
//  - Transfers: accept = in_valid & in_ready; consume = out_valid & out_ready.
//    Accept-to-out_valid latency 1 cycle. Bundles leave strictly in order, none dropped
//    or duplicated.
//  - SKID_EN=0: in_ready = out_ready | ~out_valid. On accept, main entry loads. Otherwise,
//    on consume, main entry goes empty. Otherwise it holds.
//  - SKID_EN=1: states EMPTY(0) / ONE(1) / FULL(2); in_ready = (state != FULL), registered.
//    EMPTY  accept -> ONE.
//    ONE    accept & ~consume -> FULL (new bundle into skid);
//           consume & ~accept -> EMPTY;
//           both -> ONE (main reloads from input).
//    FULL   consume -> ONE (main reloads from skid). No accept possible.
//  - Output always driven from main entry.
//  - Bubble rule: when out_valid=0, WB_out and M_out read 0, so no spurious reg/mem write.
//    ALUData_out, WriteData_out and Regd_out hold their last value (don't-care).
//  - flush_in=1 at posedge: state -> EMPTY, main/skid valid cleared, WB/M regs zeroed.
//    flush_in has priority over a same-cycle accept: that bundle is discarded, but in_ready
//    still reads as asserted, so upstream treats it as taken.
//  - reset_in has priority over flush_in. Reset mid-FULL discards both entries.
//  - stall_cnt increments when out_valid & ~out_ready; holds at 2^CNT_W-1. Cleared only by
//    reset. Flush does not clear it.
//  - Parameter changes affect widths only, never timing.
// STRUCTURE
//  - Shared package exmem_pkg: WB_W/M_W/DATA_W/REGD_W defaults, packed bundle typedef
//    exmem_bundle_t, and BUNDLE_W = WB_W+M_W+2*DATA_W+REGD_W.
//    Bundle field order, MSB to LSB: {WB, M, ALUData, WriteData, Regd}.
//  - Sub-module pipe_skid_core (params PAYLOAD_W, SKID_EN): generic payload handshake
//    buffer with flush.
//  - exmem_pipe_stage packs/unpacks fields, applies the bubble rule and owns stall_cnt.
// TESTING
//  1 Reset: hold reset_in 2 cycles with in_valid=1 -> out_valid=0, all outputs 0,
//    stall_cnt=0, in_ready=1 after release.
//  2 Streaming: out_ready=1; push ALUData 0x10,0x20,0x30 on consecutive cycles
//    -> same values on out 1 cycle later; in_ready stays 1; stall_cnt=0.
//  3 Backpressure (SKID_EN=1): out_ready=0; push 0xA, 0xB -> in_ready drops after 2nd;
//    raise out_ready -> 0xA then 0xB out; stall_cnt counts the held cycles exactly.
//  4 Flush: FULL with WB_in=2'b11; pulse flush_in together with in_valid (0xC)
//    -> next cycle out_valid=0, WB_out=M_out=0, 0xC never appears.
//  5 Saturation: CNT_W=4; out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15 and holds.
//  6 SKID_EN=0 regression: in_ready == out_ready|~out_valid every cycle. Random
//    in_valid/out_ready over 1000 bundles -> scoreboard in-order, no loss.

Source files
------------

// File: rtl/exmem_pkg.sv
// Shared EX/MEM definitions: default field widths, bundle layout and width helper.
package exmem_pkg;

    localparam int unsigned WB_W   = 2;
    localparam int unsigned M_W    = 2;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned REGD_W = 5;

    function automatic int unsigned bundle_width(input int unsigned wb_w,
                                                 input int unsigned m_w,
                                                 input int unsigned data_w,
                                                 input int unsigned regd_w);
        return wb_w + m_w + 2 * data_w + regd_w;
    endfunction

    localparam int unsigned BUNDLE_W = bundle_width(WB_W, M_W, DATA_W, REGD_W);

    // Field order MSB to LSB: {WB, M, ALUData, WriteData, Regd}
    typedef struct packed {
        logic [WB_W-1:0]   wb;
        logic [M_W-1:0]    m;
        logic [DATA_W-1:0] alu_data;
        logic [DATA_W-1:0] write_data;
        logic [REGD_W-1:0] regd;
    } exmem_bundle_t;

endpackage

// File: rtl/pipe_skid_core.sv
// Generic valid/ready payload buffer: single entry or 2-entry skid with registered in_ready.
// Bits set in CLR_MASK are zeroed whenever the main entry goes empty.
module pipe_skid_core #(
    parameter int unsigned           PAYLOAD_W = 8,
    parameter int unsigned           SKID_EN   = 1,
    parameter logic [PAYLOAD_W-1:0]  CLR_MASK  = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [PAYLOAD_W-1:0]   main_q, main_d;
    logic [PAYLOAD_W-1:0]   skid_q, skid_d;
    logic                   out_valid_q, out_valid_d;
    logic                   in_ready_q, in_ready_d;
    logic                   accept;
    logic                   consume;

    assign in_ready  = (SKID_EN != 0) ? in_ready_q : (out_ready | ~out_valid_q);
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid_q & out_ready;

    // Without the skid, accept in ONE implies consume, so FULL is never reached.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_ONE;
                    main_d  = in_data;
                end
            end
            ST_ONE: begin
                if (accept && consume) begin
                    main_d = in_data;
                end else if (accept) begin
                    state_d = ST_FULL;
                    skid_d  = in_data;
                end else if (consume) begin
                    state_d = ST_EMPTY;
                    main_d  = main_q & ~CLR_MASK;
                end
            end
            ST_FULL: begin
                if (consume) begin
                    state_d = ST_ONE;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        // Flush wins over any same-cycle accept; the offered bundle is dropped.
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = main_q & ~CLR_MASK;
        end
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

endmodule

// File: rtl/exmem_pipe_stage.sv
// EX/MEM pipeline stage: handshake buffer around the packed bundle, control bubbling
// on empty, and a saturating count of stalled output cycles.
module exmem_pipe_stage #(
    parameter int unsigned WB_W    = exmem_pkg::WB_W,
    parameter int unsigned M_W     = exmem_pkg::M_W,
    parameter int unsigned DATA_W  = exmem_pkg::DATA_W,
    parameter int unsigned REGD_W  = exmem_pkg::REGD_W,
    parameter int unsigned SKID_EN = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset_in,
    input  logic              flush_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WB_W-1:0]   WB_in,
    input  logic [M_W-1:0]    M_in,
    input  logic [DATA_W-1:0] ALUData_in,
    input  logic [DATA_W-1:0] WriteData_in,
    input  logic [REGD_W-1:0] Regd_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WB_W-1:0]   WB_out,
    output logic [M_W-1:0]    M_out,
    output logic [DATA_W-1:0] ALUData_out,
    output logic [DATA_W-1:0] WriteData_out,
    output logic [REGD_W-1:0] Regd_out,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int unsigned PAYLOAD_W = exmem_pkg::bundle_width(WB_W, M_W, DATA_W, REGD_W);
    localparam int unsigned CTRL_W    = WB_W + M_W;
    localparam int unsigned DP_W      = PAYLOAD_W - CTRL_W;
    // WB and M sit at the top of the bundle; they are the fields forced to 0 on a bubble.
    localparam logic [PAYLOAD_W-1:0] CTRL_MASK = {{CTRL_W{1'b1}}, {DP_W{1'b0}}};

    typedef struct packed {
        logic [WB_W-1:0]   wb;
        logic [M_W-1:0]    m;
        logic [DATA_W-1:0] alu_data;
        logic [DATA_W-1:0] write_data;
        logic [REGD_W-1:0] regd;
    } bundle_t;

    bundle_t          in_bundle;
    bundle_t          out_bundle;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        in_bundle.wb         = WB_in;
        in_bundle.m          = M_in;
        in_bundle.alu_data   = ALUData_in;
        in_bundle.write_data = WriteData_in;
        in_bundle.regd       = Regd_in;
    end

    pipe_skid_core #(
        .PAYLOAD_W (PAYLOAD_W),
        .SKID_EN   (SKID_EN),
        .CLR_MASK  (CTRL_MASK)
    ) u_core (
        .clk       (clk),
        .rst       (reset_in),
        .flush     (flush_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_bundle),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_bundle)
    );

    assign WB_out        = out_bundle.wb;
    assign M_out         = out_bundle.m;
    assign ALUData_out   = out_bundle.alu_data;
    assign WriteData_out = out_bundle.write_data;
    assign Regd_out      = out_bundle.regd;

    // Stall counter saturates at all-ones; only reset clears it.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset_in) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_exmem_pipe_stage.sv
// Scoreboard bench for exmem_pipe_stage: skid configs (16- and 4-bit counters) share
// directed stimulus; a single-entry config runs a random in-order stream.
module tb_exmem_pipe_stage;
    import exmem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Shared stimulus for the two skid instances
    logic              reset_in, flush_in, in_valid, out_ready;
    logic [WB_W-1:0]   wb_in;
    logic [M_W-1:0]    m_in;
    logic [DATA_W-1:0] alu_in, wd_in;
    logic [REGD_W-1:0] regd_in;

    logic              a_in_ready, a_out_valid, s_in_ready, s_out_valid;
    logic [WB_W-1:0]   a_wb, s_wb;
    logic [M_W-1:0]    a_m, s_m;
    logic [DATA_W-1:0] a_alu, a_wd, s_alu, s_wd;
    logic [REGD_W-1:0] a_regd, s_regd;
    logic [15:0]       a_stall;
    logic [3:0]        s_stall;

    // Single-entry instance stimulus/outputs
    logic              n_flush = 1'b0;
    logic              n_in_valid, n_out_ready, n_in_ready, n_out_valid;
    logic [WB_W-1:0]   n_wb_in, n_wb;
    logic [M_W-1:0]    n_m_in, n_m;
    logic [DATA_W-1:0] n_alu_in, n_wd_in, n_alu, n_wd;
    logic [REGD_W-1:0] n_regd_in, n_regd;
    logic [15:0]       n_stall;

    exmem_pipe_stage #(.SKID_EN(1), .CNT_W(16)) dut_a (
        .clk(clk), .reset_in(reset_in), .flush_in(flush_in),
        .in_valid(in_valid), .in_ready(a_in_ready),
        .WB_in(wb_in), .M_in(m_in), .ALUData_in(alu_in), .WriteData_in(wd_in), .Regd_in(regd_in),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .WB_out(a_wb), .M_out(a_m), .ALUData_out(a_alu), .WriteData_out(a_wd), .Regd_out(a_regd),
        .stall_cnt(a_stall)
    );

    exmem_pipe_stage #(.SKID_EN(1), .CNT_W(4)) dut_s (
        .clk(clk), .reset_in(reset_in), .flush_in(flush_in),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .WB_in(wb_in), .M_in(m_in), .ALUData_in(alu_in), .WriteData_in(wd_in), .Regd_in(regd_in),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .WB_out(s_wb), .M_out(s_m), .ALUData_out(s_alu), .WriteData_out(s_wd), .Regd_out(s_regd),
        .stall_cnt(s_stall)
    );

    exmem_pipe_stage #(.SKID_EN(0), .CNT_W(16)) dut_n (
        .clk(clk), .reset_in(reset_in), .flush_in(n_flush),
        .in_valid(n_in_valid), .in_ready(n_in_ready),
        .WB_in(n_wb_in), .M_in(n_m_in), .ALUData_in(n_alu_in), .WriteData_in(n_wd_in), .Regd_in(n_regd_in),
        .out_valid(n_out_valid), .out_ready(n_out_ready),
        .WB_out(n_wb), .M_out(n_m), .ALUData_out(n_alu), .WriteData_out(n_wd), .Regd_out(n_regd),
        .stall_cnt(n_stall)
    );

    logic [BUNDLE_W-1:0] a_got, s_got, n_got, in_b, n_in_b;
    assign a_got  = {a_wb, a_m, a_alu, a_wd, a_regd};
    assign s_got  = {s_wb, s_m, s_alu, s_wd, s_regd};
    assign n_got  = {n_wb, n_m, n_alu, n_wd, n_regd};
    assign in_b   = {wb_in, m_in, alu_in, wd_in, regd_in};
    assign n_in_b = {n_wb_in, n_m_in, n_alu_in, n_wd_in, n_regd_in};

    exmem_bundle_t q_a[$];
    exmem_bundle_t q_n[$];
    exmem_bundle_t exp_a, exp_n;
    int            n_rcvd = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected bundles enter the skid scoreboard on accept; reset/flush drop held ones.
    always @(posedge clk) begin
        if (reset_in || flush_in) q_a.delete();
        else if (in_valid && a_in_ready) q_a.push_back(exmem_bundle_t'(in_b));
    end

    always @(negedge clk) begin
        if (a_out_valid && out_ready) begin
            if (q_a.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL a_unexpected_out actual=0x%0h required=none t=%0t", a_got, $time);
            end else begin
                exp_a = q_a.pop_front();
                chk("a_data", 128'(a_got), 128'(exp_a));
                chk("s_data", 128'(s_got), 128'(exp_a));
            end
        end
        if (!a_out_valid) chk("a_bubble_ctrl", 128'({a_wb, a_m}), 128'(0));
    end

    // Independent occupancy model for the single-entry instance
    logic n_model_vld = 1'b0;
    logic n_model_rdy;
    assign n_model_rdy = n_out_ready | ~n_model_vld;

    always @(posedge clk) begin
        if (reset_in) begin
            n_model_vld <= 1'b0;
            q_n.delete();
        end else if (n_in_valid && n_model_rdy) begin
            n_model_vld <= 1'b1;
            q_n.push_back(exmem_bundle_t'(n_in_b));
        end else if (n_model_vld && n_out_ready) begin
            n_model_vld <= 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("n_in_ready", 128'(n_in_ready), 128'(n_model_rdy));
        chk("n_out_valid", 128'(n_out_valid), 128'(n_model_vld));
        if (n_out_valid && n_out_ready) begin
            if (q_n.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL n_unexpected_out actual=0x%0h required=none t=%0t", n_got, $time);
            end else begin
                exp_n = q_n.pop_front();
                chk("n_data", 128'(n_got), 128'(exp_n));
                n_rcvd++;
            end
        end
        if (!n_out_valid) chk("n_bubble_ctrl", 128'({n_wb, n_m}), 128'(0));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic exmem_bundle_t mk(input logic [31:0] alu, input logic [1:0] wb, input logic [1:0] m);
        exmem_bundle_t b;
        b.wb         = wb;
        b.m          = m;
        b.alu_data   = alu;
        b.write_data = alu ^ 32'hA5A5_0000;
        b.regd       = alu[4:0];
        return b;
    endfunction

    task automatic drive(input exmem_bundle_t b);
        in_valid = 1'b1;
        wb_in    = b.wb;
        m_in     = b.m;
        alu_in   = b.alu_data;
        wd_in    = b.write_data;
        regd_in  = b.regd;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_in = 1'b1; flush_in = 1'b0; out_ready = 1'b0;
        n_in_valid = 1'b0; n_out_ready = 1'b0;
        n_wb_in = '0; n_m_in = '0; n_alu_in = '0; n_wd_in = '0; n_regd_in = '0;
        drive(mk(32'h55, 2'b11, 2'b11));

        // Reset held two cycles with in_valid high
        cyc(); cyc();
        reset_in = 1'b0; in_valid = 1'b0;
        chk("rst_out_valid", 128'(a_out_valid), 128'(0));
        chk("rst_outputs", 128'(a_got), 128'(0));
        chk("rst_stall", 128'(a_stall), 128'(0));
        chk("rst_in_ready", 128'(a_in_ready), 128'(1));
        chk("rst_s_in_ready", 128'(s_in_ready), 128'(1));

        // Streaming at full rate
        out_ready = 1'b1;
        drive(mk(32'h10, 2'b01, 2'b10)); cyc();
        chk("stream_in_ready0", 128'(a_in_ready), 128'(1));
        chk("stream_latency_valid", 128'(a_out_valid), 128'(1));
        chk("stream_latency_alu", 128'(a_alu), 128'(32'h10));
        drive(mk(32'h20, 2'b10, 2'b01)); cyc();
        chk("stream_in_ready1", 128'(a_in_ready), 128'(1));
        drive(mk(32'h30, 2'b11, 2'b00)); cyc();
        chk("stream_in_ready2", 128'(a_in_ready), 128'(1));
        in_valid = 1'b0;
        cyc(); cyc();
        chk("stream_drained_valid", 128'(a_out_valid), 128'(0));
        chk("stream_stall", 128'(a_stall), 128'(0));
        chk("stream_queue_empty", 128'(q_a.size()), 128'(0));

        // Backpressure fills the skid
        out_ready = 1'b0;
        drive(mk(32'hA, 2'b01, 2'b01)); cyc();
        chk("bp_in_ready_one", 128'(a_in_ready), 128'(1));
        drive(mk(32'hB, 2'b10, 2'b10)); cyc();
        in_valid = 1'b0;
        chk("bp_in_ready_full", 128'(a_in_ready), 128'(0));
        chk("bp_stall1", 128'(a_stall), 128'(1));
        repeat (3) cyc();
        chk("bp_stall4", 128'(a_stall), 128'(4));
        chk("bp_head_alu", 128'(a_alu), 128'(32'hA));
        out_ready = 1'b1;
        cyc(); cyc();
        chk("bp_drained_valid", 128'(a_out_valid), 128'(0));
        chk("bp_in_ready_back", 128'(a_in_ready), 128'(1));
        chk("bp_stall_hold", 128'(a_stall), 128'(4));

        // Flush from FULL, then flush racing an accept in ONE
        out_ready = 1'b0;
        drive(mk(32'hD1, 2'b11, 2'b11)); cyc();
        drive(mk(32'hD2, 2'b11, 2'b11)); cyc();
        chk("fl_full", 128'(a_in_ready), 128'(0));
        flush_in = 1'b1;
        drive(mk(32'hC, 2'b11, 2'b01)); cyc();
        flush_in = 1'b0; in_valid = 1'b0;
        chk("fl_out_valid", 128'(a_out_valid), 128'(0));
        chk("fl_ctrl_zero", 128'({a_wb, a_m}), 128'(0));
        chk("fl_in_ready", 128'(a_in_ready), 128'(1));
        chk("fl_stall_kept", 128'(a_stall), 128'(6));
        drive(mk(32'hE1, 2'b10, 2'b00)); cyc();
        flush_in = 1'b1;
        drive(mk(32'hC, 2'b11, 2'b01));
        chk("fl_in_ready_during", 128'(a_in_ready), 128'(1));
        cyc();
        flush_in = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("fl2_stall", 128'(a_stall), 128'(7));
        for (int i = 0; i < 3; i++) begin
            chk("fl2_no_c", 128'(a_out_valid), 128'(0));
            cyc();
        end

        // Counter saturation in the 4-bit instance
        out_ready = 1'b0;
        drive(mk(32'h77, 2'b01, 2'b11)); cyc();
        in_valid = 1'b0;
        repeat (20) cyc();
        chk("sat_a_stall", 128'(a_stall), 128'(27));
        chk("sat_s_stall", 128'(s_stall), 128'(15));
        repeat (2) cyc();
        chk("sat_s_hold", 128'(s_stall), 128'(15));
        out_ready = 1'b1;
        cyc();
        chk("sat_a_after", 128'(a_stall), 128'(29));

        // Reset while FULL discards both entries
        out_ready = 1'b0;
        drive(mk(32'h91, 2'b01, 2'b01)); cyc();
        drive(mk(32'h92, 2'b10, 2'b10)); cyc();
        chk("rf_full", 128'(a_in_ready), 128'(0));
        chk("rf_stall", 128'(a_stall), 128'(30));
        reset_in = 1'b1;
        drive(mk(32'h93, 2'b11, 2'b11)); cyc();
        reset_in = 1'b0; in_valid = 1'b0;
        chk("rf_out_valid", 128'(a_out_valid), 128'(0));
        chk("rf_outputs", 128'(a_got), 128'(0));
        chk("rf_stall_clr", 128'(a_stall), 128'(0));
        chk("rf_s_stall_clr", 128'(s_stall), 128'(0));
        chk("rf_in_ready", 128'(a_in_ready), 128'(1));
        out_ready = 1'b1;
        cyc(); cyc();
        chk("rf_nothing_left", 128'(a_out_valid), 128'(0));

        // Random stream through the single-entry instance
        begin : rand_phase
            int sent;
            int budget;
            sent   = 0;
            budget = 0;
            while ((n_rcvd < 1000) && (budget < 20000)) begin
                n_in_valid  = (sent < 1000) && ($urandom_range(3) != 0);
                n_wb_in     = 2'($urandom);
                n_m_in      = 2'($urandom);
                n_alu_in    = {16'(sent), 16'($urandom)};
                n_wd_in     = $urandom;
                n_regd_in   = 5'($urandom);
                n_out_ready = ($urandom_range(3) != 0);
                @(negedge clk);
                if (n_in_valid && n_model_rdy) sent++;
                cyc();
                budget++;
            end
            n_in_valid = 1'b0;
            chk("n_received", 128'(n_rcvd), 128'(1000));
            chk("n_queue_empty", 128'(q_n.size()), 128'(0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
